obi_sram_arb: RTL and testbench

- Two-manager to one-subordinate OBI arbiter that sits directly upstream of the OBI SRAM subordinate.
- Typical connection: manager 0 is the core instruction port, manager 1 the core data port. The single OBI output drives the SRAM.
- Round-robin request arbitration. A response-owner FIFO routes each rvalid/rdata/err back to the manager that issued the request.
- Handles any subordinate response latency of at least 1 cycle, in order, with up to MaxTrans requests outstanding.

---
 rtl/obi_sram_arb_if.sv | 28 ++
 rtl/obi_sram_arb.sv | 116 +++++++++++
 tb/tb_obi_sram_arb.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_sram_arb_if.sv
// OBI request/response bundle shared by the arbiter's manager and subordinate sides.
// The master side drives the request payload; the slave side returns grant and response.
interface obi_sram_arb_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic                 req;
  logic                 gnt;
  logic [AddrWidth-1:0] addr;
  logic                 we;
  logic [BeWidth-1:0]   be;
  logic [DataWidth-1:0] wdata;
  logic                 rvalid;
  logic [DataWidth-1:0] rdata;
  logic                 err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/obi_sram_arb.sv
// Two-manager round-robin OBI arbiter with an owner FIFO steering in-order responses back.
// Zero added latency on both paths; s_req drops when MaxTrans are outstanding (no same-cycle bypass).
module obi_sram_arb #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  obi_sram_arb_if.slave  m0,
  obi_sram_arb_if.slave  m1,
  obi_sram_arb_if.master s
);
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic [MaxTrans-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                rr_last_q, rr_last_d;
  logic                hold_vld_q, hold_vld_d;
  logic                hold_sel_q, hold_sel_d;

  logic sel, full, empty, push, pop, head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CntW'(MaxTrans));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // A stalled request pins sel so the payload stays stable until it is granted.
  always_comb begin
    sel = 1'b0;
    if (hold_vld_q) begin
      sel = hold_sel_q;
    end else if (m0.req && m1.req) begin
      sel = ~rr_last_q;
    end else if (m1.req) begin
      sel = 1'b1;
    end
  end

  assign s.req   = ~rst_i & (m0.req | m1.req) & ~full;
  assign s.addr  = sel ? m1.addr  : m0.addr;
  assign s.we    = sel ? m1.we    : m0.we;
  assign s.be    = sel ? m1.be    : m0.be;
  assign s.wdata = sel ? m1.wdata : m0.wdata;

  assign m0.gnt = s.req & s.gnt & ~sel;
  assign m1.gnt = s.req & s.gnt &  sel;

  assign push = s.req & s.gnt;
  assign pop  = ~rst_i & s.rvalid & ~empty;

  assign m0.rvalid = pop & ~head;
  assign m1.rvalid = pop &  head;
  assign m0.rdata  = s.rdata;
  assign m1.rdata  = s.rdata;
  assign m0.err    = pop & ~head & s.err;
  assign m1.err    = pop &  head & s.err;

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rr_last_d  = rr_last_q;
    hold_vld_d = s.req & ~s.gnt;
    hold_sel_d = sel;
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      rr_last_d        = sel;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_last_q  <= 1'b1;
      hold_vld_q <= 1'b0;
      hold_sel_q <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rr_last_q  <= rr_last_d;
      hold_vld_q <= hold_vld_d;
      hold_sel_q <= hold_sel_d;
    end
  end

  // A response with nothing outstanding is a subordinate protocol violation; it is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(s.rvalid && empty))
        else $warning("obi_sram_arb: unexpected s_rvalid with empty owner FIFO, response dropped");
    end
  end
endmodule

// File: tb/tb_obi_sram_arb.sv
// Directed bench for obi_sram_arb: arbitration order, stall hold, full throttle, routing, reset.
module tb_obi_sram_arb;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  obi_sram_arb_if #(.AddrWidth(32), .DataWidth(32)) m0_if ();
  obi_sram_arb_if #(.AddrWidth(32), .DataWidth(32)) m1_if ();
  obi_sram_arb_if #(.AddrWidth(32), .DataWidth(32)) s_if ();

  obi_sram_arb #(.AddrWidth(32), .DataWidth(32), .MaxTrans(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    m0_if.req = 0; m0_if.addr = '0; m0_if.we = 0; m0_if.be = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.addr = '0; m1_if.we = 0; m1_if.be = '0; m1_if.wdata = '0;
    s_if.gnt = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.err = 0;
  endtask

  task automatic rsp(input logic v, input logic [31:0] d, input logic e);
    s_if.rvalid = v; s_if.rdata = d; s_if.err = e;
  endtask

  task automatic pulse_reset();
    idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_i = 1'b1;
    tick();
    // Reset outputs with every input active
    m0_if.req = 1; m1_if.req = 1; s_if.gnt = 1; rsp(1, 32'h1111, 1);
    #1;
    check("rst_s_req", s_if.req, 0);
    check("rst_m0_gnt", m0_if.gnt, 0);
    check("rst_m1_gnt", m1_if.gnt, 0);
    check("rst_m0_rvalid", m0_if.rvalid, 0);
    check("rst_m1_rvalid", m1_if.rvalid, 0);
    check("rst_m1_err", m1_if.err, 0);
    idle();
    rst_i = 1'b0;
    tick();

    // Single manager read
    m0_if.req = 1; m0_if.addr = 32'h100; s_if.gnt = 1;
    #1;
    check("single_gnt", m0_if.gnt, 1);
    check("single_addr", s_if.addr, 32'h100);
    check("single_m1_gnt", m1_if.gnt, 0);
    tick();
    m0_if.req = 0; rsp(1, 32'hDEADBEEF, 0);
    #1;
    check("single_rvalid", m0_if.rvalid, 1);
    check("single_rdata", m0_if.rdata, 32'hDEADBEEF);
    check("single_m1_rvalid", m1_if.rvalid, 0);
    tick();
    rsp(0, 0, 0);

    // Contention from reset: grants alternate m0, m1, m0, m1
    pulse_reset();
    m0_if.req = 1; m0_if.addr = 32'h200; m1_if.req = 1; m1_if.addr = 32'h300; s_if.gnt = 1;
    #1;
    check("cont0_m0_gnt", m0_if.gnt, 1);
    check("cont0_m1_gnt", m1_if.gnt, 0);
    check("cont0_addr", s_if.addr, 32'h200);
    tick();
    rsp(1, 32'hA0, 0);
    #1;
    check("cont1_m1_gnt", m1_if.gnt, 1);
    check("cont1_m0_gnt", m0_if.gnt, 0);
    check("cont1_m0_rvalid", m0_if.rvalid, 1);
    check("cont1_m0_rdata", m0_if.rdata, 32'hA0);
    check("cont1_m1_rvalid", m1_if.rvalid, 0);
    tick();
    rsp(1, 32'hA1, 0);
    #1;
    check("cont2_m0_gnt", m0_if.gnt, 1);
    check("cont2_m1_rvalid", m1_if.rvalid, 1);
    check("cont2_m0_rvalid", m0_if.rvalid, 0);
    tick();
    rsp(1, 32'hA2, 0);
    #1;
    check("cont3_m1_gnt", m1_if.gnt, 1);
    check("cont3_m0_rvalid", m0_if.rvalid, 1);
    check("cont3_m0_rdata", m0_if.rdata, 32'hA2);
    tick();
    m0_if.req = 0; m1_if.req = 0; rsp(1, 32'hA3, 0);
    #1;
    check("cont4_s_req", s_if.req, 0);
    check("cont4_m1_rvalid", m1_if.rvalid, 1);
    check("cont4_m1_rdata", m1_if.rdata, 32'hA3);
    tick();
    idle();

    // Stall: sel stays on m1 while it waits, even after m0 joins
    pulse_reset();
    m1_if.req = 1; m1_if.addr = 32'h400; s_if.gnt = 0;
    #1;
    check("stall0_s_req", s_if.req, 1);
    check("stall0_addr", s_if.addr, 32'h400);
    tick();
    m0_if.req = 1; m0_if.addr = 32'h500;
    #1;
    check("stall1_addr", s_if.addr, 32'h400);
    check("stall1_m0_gnt", m0_if.gnt, 0);
    tick();
    #1;
    check("stall2_addr", s_if.addr, 32'h400);
    tick();
    s_if.gnt = 1;
    #1;
    check("stall3_m1_gnt", m1_if.gnt, 1);
    check("stall3_m0_gnt", m0_if.gnt, 0);
    check("stall3_addr", s_if.addr, 32'h400);
    tick();
    m1_if.req = 0; rsp(1, 32'hB1, 0);
    #1;
    check("stall4_m0_gnt", m0_if.gnt, 1);
    check("stall4_addr", s_if.addr, 32'h500);
    check("stall4_m1_rvalid", m1_if.rvalid, 1);
    tick();
    m0_if.req = 0; rsp(1, 32'hB0, 0);
    #1;
    check("stall5_m0_rvalid", m0_if.rvalid, 1);
    tick();
    idle();

    // Full: two grants, then throttle with no same-cycle bypass
    pulse_reset();
    m0_if.req = 1; m0_if.addr = 32'h600; s_if.gnt = 1;
    #1;
    check("full0_gnt", m0_if.gnt, 1);
    tick();
    #1;
    check("full1_gnt", m0_if.gnt, 1);
    tick();
    #1;
    check("full2_s_req", s_if.req, 0);
    check("full2_gnt", m0_if.gnt, 0);
    rsp(1, 32'hC0, 0);
    #1;
    check("full2_nobypass", s_if.req, 0);
    check("full2_rvalid", m0_if.rvalid, 1);
    tick();
    rsp(0, 0, 0);
    #1;
    check("full3_s_req", s_if.req, 1);
    check("full3_gnt", m0_if.gnt, 1);
    tick();
    m0_if.req = 0; rsp(1, 32'hC1, 0);
    #1;
    check("full4_rvalid", m0_if.rvalid, 1);
    tick();
    #1;
    check("full5_rvalid", m0_if.rvalid, 1);
    tick();
    idle();

    // Error response on an m1 write
    m1_if.req = 1; m1_if.we = 1; m1_if.addr = 32'h700; m1_if.wdata = 32'h12345678;
    m1_if.be = 4'b0011; s_if.gnt = 1;
    #1;
    check("wr_m1_gnt", m1_if.gnt, 1);
    check("wr_we", s_if.we, 1);
    check("wr_wdata", s_if.wdata, 32'h12345678);
    check("wr_be", s_if.be, 32'h3);
    tick();
    m1_if.req = 0; rsp(1, 32'h0, 1);
    #1;
    check("wr_m1_rvalid", m1_if.rvalid, 1);
    check("wr_m1_err", m1_if.err, 1);
    check("wr_m0_err", m0_if.err, 0);
    check("wr_m0_rvalid", m0_if.rvalid, 0);
    tick();
    idle();

    // Reset with two outstanding, then a stray response
    m0_if.req = 1; m0_if.addr = 32'h800; m1_if.req = 1; m1_if.addr = 32'h900; s_if.gnt = 1;
    #1;
    check("mid0_m0_gnt", m0_if.gnt, 1);
    tick();
    #1;
    check("mid1_m1_gnt", m1_if.gnt, 1);
    tick();
    rst_i = 1'b1;
    #1;
    check("mid_rst_s_req", s_if.req, 0);
    tick();
    rst_i = 1'b0;
    m0_if.req = 0; m1_if.req = 0; rsp(1, 32'hEE, 0);
    #1;
    check("stray_m0_rvalid", m0_if.rvalid, 0);
    check("stray_m1_rvalid", m1_if.rvalid, 0);
    tick();
    rsp(0, 0, 0);
    m0_if.req = 1; m1_if.req = 1;
    #1;
    check("post_tie_m0_gnt", m0_if.gnt, 1);
    check("post_tie_m1_gnt", m1_if.gnt, 0);
    tick();
    #1;
    check("post1_m1_gnt", m1_if.gnt, 1);
    tick();
    #1;
    check("post2_full", s_if.req, 0);
    m0_if.req = 0; m1_if.req = 0; rsp(1, 32'hF0, 0);
    #1;
    check("post2_m0_rvalid", m0_if.rvalid, 1);
    tick();
    rsp(1, 32'hF1, 0);
    #1;
    check("post3_m1_rvalid", m1_if.rvalid, 1);
    check("post3_m1_rdata", m1_if.rdata, 32'hF1);
    tick();
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
